// File: rtl/cache_control.sv
// cache_control: tag/valid/dirty control for an 8-line direct-mapped 128-bit-line cache
//   CPU side    : mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata in, mem_rdata/mem_resp out
//   memory side : pmem_address/pmem_read/pmem_write/pmem_wdata out, pmem_rdata/pmem_resp in
//   array side  : array_write/array_index/array_datain out, array_dataout in
module cache_control #(
  parameter int tag_width = 9,
  parameter int line_width = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_byte_enable,
  input  logic [15:0]           mem_wdata,
  output logic [15:0]           mem_rdata,
  output logic                  mem_resp,
  output logic [15:0]           pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [line_width-1:0] pmem_wdata,
  input  logic [line_width-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  array_write,
  output logic [2:0]            array_index,
  output logic [line_width-1:0] array_datain,
  input  logic [line_width-1:0] array_dataout
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state_q, state_d;
  logic [tag_width-1:0] tag_q [8];
  logic [7:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [2:0] idx, w;
  logic req, hit, fill_done;
  logic [15:0] old_word, new_word;
  logic [line_width-1:0] merged;
  assign idx = mem_address[6:4];
  assign w = mem_address[3:1];
  assign req = mem_read | mem_write;
  assign hit = valid_q[idx] && (tag_q[idx] == mem_address[15:16-tag_width]);
  assign array_index = idx;
  assign mem_rdata = array_dataout[16*w +: 16];
  assign old_word = array_dataout[16*w +: 16];
  assign new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                     mem_byte_enable[0] ? mem_wdata[7:0] : old_word[7:0]};
  always_comb begin
    merged = array_dataout;
    merged[16*w +: 16] = new_word;
  end
  // A write (or read+write) hit completes in the request cycle; a miss spends
  // one decision cycle in IDLE before any memory strobe rises.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    fill_done = 1'b0;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    array_write = 1'b0;
    array_datain = '0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          array_write = mem_write;
          array_datain = mem_write ? merged : '0;
          dirty_d[idx] = dirty_q[idx] | mem_write;
        end else if (req) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tag_q[idx], idx, 4'b0};
        pmem_wdata = array_dataout;
        if (pmem_resp) begin
          state_d = FILL;
          dirty_d[idx] = 1'b0;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0};
        if (pmem_resp) begin
          array_write = 1'b1;
          array_datain = pmem_rdata;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          fill_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // Tags need no reset: a tag is only consulted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[idx] <= mem_address[15:16-tag_width];
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed bench with a behavioural cache model, array and memory
module tb_cache_control;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] mem_address = '0, mem_wdata = '0, mem_rdata, pmem_address;
  logic mem_read = 1'b0, mem_write = 1'b0, mem_resp, pmem_read, pmem_write, pmem_resp, array_write;
  logic [1:0] mem_byte_enable = '0;
  logic [127:0] pmem_wdata, pmem_rdata, array_datain, array_dataout;
  logic [2:0] array_index;
  logic resp_r = 1'b0, stray = 1'b0;
  int cnt = 0, nvec = 0, nerr = 0;
  logic [127:0] arr [8];
  logic [127:0] mem [4096];
  int mphase = 0;
  logic [8:0] mtag [8];
  logic [7:0] mvalid = '0, mdirty = '0;
  int seen_pw, seen_pr, aw_seen, got_resp, resp_at, pw_at, pr_at;
  logic [15:0] pw_addr, pr_addr, rdata;
  logic [127:0] pw_line;

  cache_control dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .array_write(array_write), .array_index(array_index),
    .array_datain(array_datain), .array_dataout(array_dataout)
  );

  always #5 clk = ~clk;
  assign array_dataout = arr[array_index];
  assign pmem_rdata = mem[pmem_address[15:4]];
  assign pmem_resp = resp_r | stray;

  always @(posedge clk) begin
    if (array_write) arr[array_index] <= array_datain;
    if (pmem_resp && pmem_write) mem[pmem_address[15:4]] <= pmem_wdata;
  end

  // memory answers on the third cycle a strobe has been held
  always @(posedge clk) begin
    #1;
    resp_r = 1'b0;
    if (rst || !(pmem_read || pmem_write)) cnt = 0;
    else begin
      cnt++;
      if (cnt >= 3) begin
        resp_r = 1'b1;
        cnt = 0;
      end
    end
  end

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic e_resp, e_pr, e_pw, e_aw;
    logic [15:0] e_addr, wd;
    logic [127:0] e_din, line;
    logic [2:0] idx, w;
    e_resp = 0; e_pr = 0; e_pw = 0; e_aw = 0; e_addr = 0; e_din = 0;
    idx = mem_address[6:4];
    w = mem_address[3:1];
    line = arr[idx];
    if (!rst) begin
      if (mphase == 0) begin
        if (mem_read || mem_write) begin
          if (mvalid[idx] && mtag[idx] == mem_address[15:7]) begin
            e_resp = 1;
            if (mem_write) begin
              wd = line[16*w +: 16];
              if (mem_byte_enable[0]) wd[7:0] = mem_wdata[7:0];
              if (mem_byte_enable[1]) wd[15:8] = mem_wdata[15:8];
              line[16*w +: 16] = wd;
              e_aw = 1;
              e_din = line;
              mdirty[idx] = 1;
            end
          end else mphase = (mvalid[idx] && mdirty[idx]) ? 1 : 2;
        end
      end else if (mphase == 1) begin
        e_pw = 1;
        e_addr = {mtag[idx], idx, 4'b0};
        if (pmem_resp) begin
          mdirty[idx] = 0;
          mphase = 2;
        end
      end else begin
        e_pr = 1;
        e_addr = {mem_address[15:4], 4'b0};
        if (pmem_resp) begin
          e_aw = 1;
          e_din = mem[mem_address[15:4]];
          mtag[idx] = mem_address[15:7];
          mvalid[idx] = 1;
          mdirty[idx] = 0;
          mphase = 0;
        end
      end
    end
    chk("mem_resp", mem_resp, e_resp);
    chk("pmem_read", pmem_read, e_pr);
    chk("pmem_write", pmem_write, e_pw);
    chk("pmem_address", pmem_address, e_addr);
    chk("array_write", array_write, e_aw);
    chk("array_index", array_index, idx);
    if (e_aw) chk("array_datain", array_datain, e_din);
    if (e_resp) chk("mem_rdata", mem_rdata, arr[idx][16*w +: 16]);
    if (e_pw) chk("pmem_wdata", pmem_wdata, arr[idx]);
    if (rst) begin
      mphase = 0;
      mvalid = '0;
      mdirty = '0;
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = d;
    seen_pw = 0; seen_pr = 0; aw_seen = 0; got_resp = 0; resp_at = -1; pw_at = -1; pr_at = -1;
    for (int i = 0; i < 60 && got_resp == 0; i++) begin
      @(negedge clk);
      if (pmem_write && seen_pw == 0) begin seen_pw = 1; pw_at = i; pw_addr = pmem_address; pw_line = pmem_wdata; end
      if (pmem_read && seen_pr == 0) begin seen_pr = 1; pr_at = i; pr_addr = pmem_address; end
      if (array_write) aw_seen = 1;
      if (mem_resp) begin got_resp = 1; resp_at = i; rdata = mem_rdata; end
    end
    chk("got_resp", got_resp, 1);
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < 4096; l++)
      for (int i = 0; i < 8; i++)
        mem[l][16*i +: 16] <= (l == 6) ? 16'h1000 + 16'(i) : {l[7:0], 4'h0, i[3:0]};
    for (int i = 0; i < 8; i++) arr[i] <= '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", mem_resp, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_aw", array_write, 0);
    chk("rst_paddr", pmem_address, 0);
    chk("rst_datain", array_datain, 0);
    rst = 0;
    @(posedge clk); #1;
    req(1, 0, 16'h0062, 2'b00, 16'h0);
    chk("r1_pr", seen_pr, 1);
    chk("r1_praddr", pr_addr, 16'h0060);
    chk("r1_nopw", seen_pw, 0);
    chk("r1_aw", aw_seen, 1);
    chk("r1_lat", resp_at, 4);
    chk("r1_data", rdata, 16'h1001);
    req(0, 1, 16'h0064, 2'b01, 16'hABCD);
    chk("w_lat", resp_at, 0);
    chk("w_aw", aw_seen, 1);
    req(1, 0, 16'h0064, 2'b00, 16'h0);
    chk("w_rd", rdata, 16'h10CD);
    req(1, 0, 16'h0460, 2'b00, 16'h0);
    chk("d_pw", seen_pw, 1);
    chk("d_pwaddr", pw_addr, 16'h0060);
    chk("d_pwword2", pw_line[47:32], 16'h10CD);
    chk("d_praddr", pr_addr, 16'h0460);
    chk("d_order", pw_at < pr_at, 1);
    chk("d_lat", resp_at, 7);
    chk("d_data", rdata, 16'h4600);
    req(1, 0, 16'h0062, 2'b00, 16'h0);
    chk("c_nopw", seen_pw, 0);
    chk("c_praddr", pr_addr, 16'h0060);
    chk("c_data", rdata, 16'h1001);
    mem_address = 16'h0072; mem_read = 1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("f_pread", pmem_read, 1);
    #1 rst = 1;
    #1 chk("f_rst_drop", pmem_read, 0);
    @(posedge clk); #1;
    mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    req(1, 0, 16'h0062, 2'b00, 16'h0);
    chk("f_remiss", seen_pr, 1);
    chk("f_redata", rdata, 16'h1001);
    req(1, 0, 16'h0072, 2'b00, 16'h0);
    chk("f7_pr", seen_pr, 1);
    chk("f7_data", rdata, 16'h0701);
    stray = 1;
    @(posedge clk); #1;
    stray = 0;
    req(1, 0, 16'h0072, 2'b00, 16'h0);
    chk("s_lat", resp_at, 0);
    chk("s_data", rdata, 16'h0701);
    req(1, 1, 16'h0072, 2'b11, 16'h5555);
    chk("rw_lat", resp_at, 0);
    chk("rw_aw", aw_seen, 1);
    req(1, 0, 16'h0072, 2'b00, 16'h0);
    chk("rw_rd", rdata, 16'h5555);
    req(1, 0, 16'h0472, 2'b00, 16'h0);
    chk("rw_pw", seen_pw, 1);
    chk("rw_pwaddr", pw_addr, 16'h0070);
    chk("rw_pwword1", pw_line[31:16], 16'h5555);
    chk("rw_data", rdata, 16'h4701);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
